search_timer: RTL and testbench

Per-move time manager between the UCI command handler and the engine coordinator. It latches the clock time and increment (ms) issued with each `go` and derives a millisecond budget from them. A sequential shift-add multiplier converts that budget to clock cycles, and the result is counted down on the engine coordinator's time input. It replaces the ad-hoc countdown in the top level and adds budget clamping, saturation, stop handling and an expiry pulse.

---
 rtl/search_timer.sv | 157 +++++++++++++++
 tb/tb_search_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/search_timer.sv
// search_timer: per-move time budget for the engine coordinator. Latches the
// clock time and increment of each go, converts the budget to cycles and counts it down.
`timescale 1ns/1ps
`default_nettype none

module search_timer #(
  parameter int CLOCK_FREQ = 40_000_000,
  parameter int TIME_SHIFT = 3,
  parameter int MIN_MS     = 10
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        go_in,
  input  logic [31:0] go_time_in,
  input  logic [31:0] go_inc_in,
  input  logic        fixed_in,
  input  logic        stop_in,
  output logic [31:0] time_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic        expired_out
);

  localparam logic [31:0] c_cpm   = 32'(CLOCK_FREQ / 1000);
  localparam logic [31:0] c_min   = 32'(MIN_MS);
  localparam logic [2:0]  c_idle  = 3'd0;
  localparam logic [2:0]  c_clamp = 3'd1;
  localparam logic [2:0]  c_mul   = 3'd2;
  localparam logic [2:0]  c_run   = 3'd3;
  localparam logic [2:0]  c_hold  = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_t;
  logic [31:0] r_i;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;

  logic [31:0] w_b_shift;
  logic [31:0] w_b_cap;
  logic [31:0] w_b_floor;
  logic [31:0] w_b;
  logic [63:0] w_addend;
  logic [63:0] w_acc_nxt;
  logic        w_mul_done;
  logic [31:0] w_prod;
  logic [31:0] w_time_nxt;
  logic        w_valid_nxt;
  logic        w_busy_nxt;
  logic        w_exp_nxt;

  // Budget clamp: increment capped by a fraction of the clock, floored, then never over half the clock.
  assign w_b_shift = r_t >> TIME_SHIFT;
  assign w_b_cap   = (r_i < w_b_shift) ? r_i : w_b_shift;
  assign w_b_floor = (w_b_cap < c_min) ? c_min : w_b_cap;
  assign w_b       = (w_b_floor < (r_t >> 1)) ? w_b_floor : (r_t >> 1);

  assign w_addend   = {32'd0, c_cpm} << r_cnt[4:0];
  assign w_acc_nxt  = r_b[r_cnt[4:0]] ? (r_acc + w_addend) : r_acc;
  assign w_mul_done = (r_cnt == 6'd32);
  assign w_prod     = (r_acc[63:32] != 32'd0) ? 32'hFFFF_FFFF : r_acc[31:0];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= c_idle;
      time_out    <= 32'd0;
      valid_out   <= 1'b0;
      busy_out    <= 1'b0;
      expired_out <= 1'b0;
    end else begin
      r_state     <= w_next;
      time_out    <= w_time_nxt;
      valid_out   <= w_valid_nxt;
      busy_out    <= w_busy_nxt;
      expired_out <= w_exp_nxt;
    end
  end

  always_comb begin
    w_next = r_state;
    if (go_in) begin
      w_next = fixed_in ? c_hold : c_clamp;
    end else begin
      case (r_state)
        c_idle:  w_next = c_idle;
        c_clamp: w_next = stop_in ? c_idle : c_mul;
        c_mul: begin
          if (stop_in)         w_next = c_idle;
          else if (w_mul_done) w_next = (w_prod == 32'd0) ? c_hold : c_run;
        end
        c_run: begin
          if (stop_in)                w_next = c_idle;
          else if (time_out <= 32'd1) w_next = c_hold;
        end
        c_hold:  w_next = stop_in ? c_idle : c_hold;
        default: w_next = c_idle;
      endcase
    end
  end

  always_comb begin
    w_time_nxt  = time_out;
    w_valid_nxt = valid_out;
    w_exp_nxt   = 1'b0;
    if (go_in) begin
      w_time_nxt  = fixed_in ? 32'hFFFF_FFFF : 32'd0;
      w_valid_nxt = fixed_in;
    end else if (stop_in || r_state == c_idle || r_state == c_clamp) begin
      w_time_nxt  = 32'd0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        c_mul: begin
          if (w_mul_done) begin
            w_time_nxt  = w_prod;
            w_valid_nxt = 1'b1;
            w_exp_nxt   = (w_prod == 32'd0);
          end
        end
        c_run: begin
          if (time_out != 32'd0) w_time_nxt = time_out - 32'd1;
          w_exp_nxt = (time_out == 32'd1);
        end
        default: w_exp_nxt = 1'b0;
      endcase
    end
    w_busy_nxt = (w_next == c_clamp) || (w_next == c_mul);
  end

  // Multiplier runs 32 add steps (r_cnt 0..31); r_cnt==32 marks the load cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_t   <= 32'd0;
      r_i   <= 32'd0;
      r_b   <= 32'd0;
      r_acc <= 64'd0;
      r_cnt <= 6'd0;
    end else begin
      if (go_in) begin
        r_t <= go_time_in;
        r_i <= go_inc_in;
      end
      if (r_state == c_clamp) begin
        r_b   <= w_b;
        r_acc <= 64'd0;
        r_cnt <= 6'd0;
      end else if (r_state == c_mul && !w_mul_done) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_search_timer.sv
// tb_search_timer: randomized and directed checks of search_timer against an
// arithmetic budget model.
`timescale 1ns/1ps
`default_nettype none

module tb_search_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] go_time = 32'd0;
  logic [31:0] go_inc = 32'd0;
  logic        fixed = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] time_out;
  logic        valid_out;
  logic        busy_out;
  logic        expired_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_exp    = 0;

  always #5 clk = ~clk;

  search_timer #(
    .CLOCK_FREQ(1_000_000),
    .TIME_SHIFT(3),
    .MIN_MS(10)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .go_in(go),
    .go_time_in(go_time),
    .go_inc_in(go_inc),
    .fixed_in(fixed),
    .stop_in(stop),
    .time_out(time_out),
    .valid_out(valid_out),
    .busy_out(busy_out),
    .expired_out(expired_out)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (expired_out) n_exp++;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] t, input logic [31:0] i);
    logic [63:0] b;
    logic [63:0] p;
    b = (i < (t >> 3)) ? 64'(i) : 64'(t >> 3);
    if (b < 64'd10) b = 64'd10;
    if (b > 64'(t >> 1)) b = 64'(t >> 1);
    p = b * 64'd1000;
    return (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
  endfunction

  task automatic start_go(input logic [31:0] t, input logic [31:0] i, input logic fx, input logic st);
    go_time = t;
    go_inc  = i;
    fixed   = fx;
    stop    = st;
    go      = 1'b1;
    tick();
    go    = 1'b0;
    stop  = 1'b0;
    fixed = 1'b0;
  endtask

  task automatic expect_load(input string tag, input logic [31:0] exp);
    chk_eq({tag, "_busy_start"}, 64'(busy_out), 64'd1);
    chk_eq({tag, "_novalid_start"}, 64'(valid_out), 64'd0);
    repeat (33) tick();
    chk_eq({tag, "_busy_end"}, 64'(busy_out), 64'd1);
    chk_eq({tag, "_novalid_end"}, 64'(valid_out), 64'd0);
    tick();
    chk_eq({tag, "_valid"}, 64'(valid_out), 64'd1);
    chk_eq({tag, "_time"}, 64'(time_out), 64'(exp));
    chk_eq({tag, "_idle_busy"}, 64'(busy_out), 64'd0);
  endtask

  task automatic countdown(input string tag, input logic [31:0] n);
    int e0;
    e0 = n_exp;
    repeat (n - 1) tick();
    chk_eq({tag, "_one"}, 64'(time_out), 64'd1);
    chk_eq({tag, "_early_exp"}, 64'(n_exp - e0), 64'd0);
    tick();
    chk_eq({tag, "_zero"}, 64'(time_out), 64'd0);
    chk_eq({tag, "_exp"}, 64'(expired_out), 64'd1);
    tick();
    chk_eq({tag, "_exp_once"}, 64'(n_exp - e0), 64'd1);
    chk_eq({tag, "_hold_valid"}, 64'(valid_out), 64'd1);
    chk_eq({tag, "_hold_time"}, 64'(time_out), 64'd0);
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_eq({tag, "_stop_valid"}, 64'(valid_out), 64'd0);
    chk_eq({tag, "_stop_time"}, 64'(time_out), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    logic [31:0] t, i, exp;
    repeat (3) tick();
    chk_eq("rst_time", 64'(time_out), 64'd0);
    chk_eq("rst_valid", 64'(valid_out), 64'd0);
    chk_eq("rst_busy", 64'(busy_out), 64'd0);
    chk_eq("rst_exp", 64'(expired_out), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic budget, then a go in RUN restarts with a short budget that expires.
    start_go(32'd80000, 32'd2000, 1'b0, 1'b0);
    expect_load("basic", 32'd2_000_000);
    repeat (5) tick();
    chk_eq("basic_dec", 64'(time_out), 64'd1_999_995);
    e0 = n_exp;
    start_go(32'd16, 32'd0, 1'b0, 1'b0);
    chk_eq("regos_time", 64'(time_out), 64'd0);
    expect_load("clamp16", 32'd8000);
    chk_eq("regos_noexp", 64'(n_exp - e0), 64'd0);
    countdown("cd8000", 32'd8000);
    e0 = n_exp;
    repeat (4) tick();
    chk_eq("hold_noexp", 64'(n_exp - e0), 64'd0);
    do_stop("hold");

    start_go(32'd400, 32'd5000, 1'b0, 1'b0);
    expect_load("clamp400", 32'd50_000);
    do_stop("run");

    start_go(32'd0, 32'd77, 1'b0, 1'b0);
    expect_load("zero", 32'd0);
    chk_eq("zero_exp", 64'(expired_out), 64'd1);
    tick();
    chk_eq("zero_exp_end", 64'(expired_out), 64'd0);
    chk_eq("zero_hold_valid", 64'(valid_out), 64'd1);
    do_stop("zero");

    start_go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    expect_load("sat", 32'hFFFF_FFFF);
    do_stop("sat");

    // Stop in the middle of the multiply.
    start_go(32'd16, 32'd0, 1'b0, 1'b0);
    repeat (19) tick();
    e0 = n_exp;
    do_stop("midmul");
    chk_eq("midmul_busy", 64'(busy_out), 64'd0);
    repeat (40) tick();
    chk_eq("midmul_noexp", 64'(n_exp - e0), 64'd0);
    chk_eq("midmul_idle_valid", 64'(valid_out), 64'd0);

    // go and stop together during RUN: go wins.
    start_go(32'd16, 32'd0, 1'b0, 1'b0);
    expect_load("gs_first", 32'd8000);
    repeat (3) tick();
    start_go(32'd400, 32'd5000, 1'b0, 1'b1);
    expect_load("gs_second", 32'd50_000);
    do_stop("gs");

    // Fixed mode.
    e0 = n_exp;
    start_go(32'd123, 32'd45, 1'b1, 1'b0);
    chk_eq("fixed_valid", 64'(valid_out), 64'd1);
    chk_eq("fixed_time", 64'(time_out), 64'hFFFF_FFFF);
    chk_eq("fixed_busy", 64'(busy_out), 64'd0);
    repeat (10) tick();
    chk_eq("fixed_held", 64'(time_out), 64'hFFFF_FFFF);
    chk_eq("fixed_noexp", 64'(n_exp - e0), 64'd0);
    do_stop("fixed");

    // Asynchronous reset in RUN, between clock edges.
    start_go(32'd16, 32'd0, 1'b0, 1'b0);
    expect_load("prerst", 32'd8000);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_time", 64'(time_out), 64'd0);
    chk_eq("arst_valid", 64'(valid_out), 64'd0);
    chk_eq("arst_busy", 64'(busy_out), 64'd0);
    chk_eq("arst_exp", 64'(expired_out), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    chk_eq("arst_after_valid", 64'(valid_out), 64'd0);

    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 2))
        0: begin t = $urandom; i = $urandom; end
        1: begin t = 32'($urandom_range(0, 400)); i = 32'($urandom_range(0, 100)); end
        default: begin t = 32'($urandom_range(0, 5)); i = 32'($urandom_range(0, 3)); end
      endcase
      exp = model_load(t, i);
      start_go(t, i, 1'b0, 1'b0);
      expect_load("rnd", exp);
      if (exp == 32'd0) chk_eq("rnd_exp0", 64'(expired_out), 64'd1);
      else if (exp <= 32'd3000) countdown("rnd_cd", exp);
      do_stop("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
